counter8_share_ctrl: RTL and testbench

- Round-robin controller that shares one external 8-state overflow counter among NREQ requesters.
- Each requester asks for a burst of N count pulses. The controller grants one requester at a time, clears the counter, drives cnt_en for N cycles, and watches the counter's overflow.
- It then reports done, overflow status and overflow count back to the winning requester.
- Sits between requester logic and the counter8 datapath; the controller is the counter's only driver.

---
 rtl/counter8_share_ctrl.sv | 172 +++++++++++++++++
 tb/tb_counter8_share_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter8_share_ctrl.sv
// ============================================================================
//  Module      : counter8_share_ctrl
//  Description : Round-robin controller that shares one external 8-state
//                overflow counter among NREQ requesters. It grants one
//                requester at a time, clears the counter, issues the burst of
//                count enables, and reports done/abort/overflow status.
//                Optional feature macro: OVF_STOP_EN (the first overflow seen
//                while running ends the burst early).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter8_share_ctrl #(
    parameter int NREQ      = 4,
    parameter int BURST_W   = 5,
    parameter int OVF_CNT_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BURST_W-1:0] burst_len,
    output logic [NREQ-1:0]         gnt,
    output logic                    cnt_clr,
    output logic                    cnt_en,
    input  logic                    cnt_ovf,
    output logic                    busy,
    output logic [NREQ-1:0]         done,
    output logic                    aborted,
    output logic                    ovf_seen,
    output logic [OVF_CNT_W-1:0]    ovf_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_winner;
    logic [BURST_W-1:0]   r_remaining;
    logic                 r_aborted;
    logic                 r_ovf_seen;
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    logic                 w_found;
    logic [IDX_W-1:0]     w_pick;
    logic [IDX_W-1:0]     w_idx;
    logic [NREQ-1:0]      w_winner_oh;
    logic                 w_stop;
    logic                 w_ovf_hit;

`ifdef OVF_STOP_EN
    assign w_stop = cnt_ovf;
`else
    assign w_stop = 1'b0;
`endif

    // Counter output lags its enable by one cycle, so DONE still collects an overflow.
    assign w_ovf_hit   = cnt_ovf && ((r_state == S_RUN) || (r_state == S_DONE));
    assign w_winner_oh = NREQ'(1) << r_winner;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = IDX_W'((int'(r_last) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        busy        = 1'b1;
        done        = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                gnt     = w_winner_oh;
                cnt_clr = 1'b1;
                w_state_nxt = (r_remaining == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                gnt    = w_winner_oh;
                cnt_en = 1'b1;
                if ((r_remaining == BURST_W'(1)) || !req[r_winner] || w_stop) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = w_winner_oh;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last      <= IDX_W'(NREQ - 1);
            r_winner    <= '0;
            r_remaining <= '0;
            r_aborted   <= 1'b0;
            r_ovf_seen  <= 1'b0;
            r_ovf_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner    <= w_pick;
                        r_remaining <= burst_len[w_pick*BURST_W +: BURST_W];
                        r_aborted   <= 1'b0;
                        r_ovf_seen  <= 1'b0;
                        r_ovf_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_remaining <= r_remaining - 1'b1;
                    if (!req[r_winner] || w_stop) begin
                        r_aborted <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_last <= r_winner;
                end
                default: begin
                end
            endcase
            if (w_ovf_hit) begin
                r_ovf_seen <= 1'b1;
                if (r_ovf_cnt != '1) begin
                    r_ovf_cnt <= r_ovf_cnt + 1'b1;
                end
            end
        end
    end

    assign aborted  = (r_state == S_DONE) && r_aborted;
    assign ovf_seen = r_ovf_seen;
    assign ovf_cnt  = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_counter8_share_ctrl.sv
// ============================================================================
//  Module      : tb_counter8_share_ctrl
//  Description : Self-checking bench for counter8_share_ctrl with a wrap-8
//                counter model; honours OVF_STOP_EN for expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter8_share_ctrl;

    localparam int NREQ      = 4;
    localparam int BURST_W   = 5;
    localparam int OVF_CNT_W = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*BURST_W-1:0] burst_len = '0;
    logic [NREQ-1:0]         gnt;
    logic                    cnt_clr;
    logic                    cnt_en;
    logic                    cnt_ovf;
    logic                    busy;
    logic [NREQ-1:0]         done;
    logic                    aborted;
    logic                    ovf_seen;
    logic [OVF_CNT_W-1:0]    ovf_cnt;

    logic [2:0] m_cnt = '0;
    logic       m_ovf = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int idx;
        int len;
        int exp_en;
        int exp_ovf;
        bit exp_seen;
        bit exp_abort;
    } vec_t;

    vec_t vecs[6];

    counter8_share_ctrl #(
        .NREQ      (NREQ),
        .BURST_W   (BURST_W),
        .OVF_CNT_W (OVF_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .burst_len (burst_len),
        .gnt       (gnt),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .cnt_ovf   (cnt_ovf),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .ovf_seen  (ovf_seen),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Counter model: overflow flag rises the cycle after the enable that wraps 7->0.
    always @(posedge clk) begin
        if (cnt_clr) begin
            m_cnt <= '0;
            m_ovf <= 1'b0;
        end else if (cnt_en) begin
            m_cnt <= m_cnt + 3'd1;
            m_ovf <= (m_cnt == 3'd7);
        end else begin
            m_ovf <= 1'b0;
        end
    end
    assign cnt_ovf = m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [NREQ-1:0] oh;
        int              en_cnt;
        bit              got_done;
        oh = NREQ'(1) << v.idx;
        @(negedge clk);
        req       = oh;
        burst_len = '0;
        burst_len[v.idx*BURST_W +: BURST_W] = BURST_W'(v.len);
        @(negedge clk);
        check("vec_gnt", 32'(gnt), 32'(oh));
        check("vec_clr", 32'(cnt_clr), 32'd1);
        check("vec_busy", 32'(busy), 32'd1);
        // Changing the winner's length after latching must have no effect.
        burst_len = '1;
        en_cnt    = 0;
        got_done  = 1'b0;
        for (int c = 0; c < 100 && !got_done; c++) begin
            @(negedge clk);
            if (cnt_en) en_cnt++;
            if (done != '0) begin
                got_done = 1'b1;
                check("vec_done", 32'(done), 32'(oh));
                check("vec_aborted", 32'(aborted), 32'(v.exp_abort));
                check("vec_gnt_off", 32'(gnt), 32'd0);
            end
        end
        req = '0;
        check("vec_done_seen", 32'(got_done), 32'd1);
        check("vec_enables", 32'(en_cnt), 32'(v.exp_en));
        @(negedge clk);
        check("vec_ovf_seen", 32'(ovf_seen), 32'(v.exp_seen));
        check("vec_ovf_cnt", 32'(ovf_cnt), 32'(v.exp_ovf));
        check("vec_idle", 32'(busy), 32'd0);
    endtask

    initial begin
`ifdef OVF_STOP_EN
        vecs[0] = '{0, 10,  9, 1, 1'b1, 1'b1};
        vecs[4] = '{2, 16,  9, 1, 1'b1, 1'b1};
        vecs[5] = '{3, 31,  9, 1, 1'b1, 1'b1};
`else
        vecs[0] = '{0, 10, 10, 1, 1'b1, 1'b0};
        vecs[4] = '{2, 16, 16, 2, 1'b1, 1'b0};
        vecs[5] = '{3, 31, 31, 3, 1'b1, 1'b0};
`endif
        vecs[1] = '{2,  0,  0, 0, 1'b0, 1'b0};
        vecs[2] = '{1,  7,  7, 0, 1'b0, 1'b0};
        vecs[3] = '{3,  8,  8, 1, 1'b1, 1'b0};

        // Reset then idle
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_outputs",
                  32'({gnt, cnt_clr, cnt_en, busy, done, aborted, ovf_seen, ovf_cnt}), 32'd0);
        end

        // Round robin, all four requesting, length 3 each
        begin
            int exp_order[5];
            exp_order = '{0, 1, 2, 3, 0};
            req       = '1;
            burst_len = {NREQ{BURST_W'(3)}};
            for (int k = 0; k < 5; k++) begin
                int  n;
                int  en_cnt;
                bit  got_done;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!cnt_clr && n < 20);
                check("rr_gap", 32'(n), 32'd1);
                check("rr_gnt", 32'(gnt), 32'(NREQ'(1) << exp_order[k]));
                en_cnt   = 0;
                got_done = 1'b0;
                for (int c = 0; c < 50 && !got_done; c++) begin
                    @(negedge clk);
                    if (cnt_en) en_cnt++;
                    if (done != '0) begin
                        got_done = 1'b1;
                        check("rr_done", 32'(done), 32'(NREQ'(1) << exp_order[k]));
                    end
                end
                check("rr_enables", 32'(en_cnt), 32'd3);
                @(negedge clk);
                check("rr_ovf_cnt", 32'(ovf_cnt), 32'd0);
                if (k == 4) req = '0;
            end
        end

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Abort: requester 1 drops req after 5 enables
        begin
            int en_cnt;
            bit got_done;
            bit dropped;
            @(negedge clk);
            req       = 4'b0010;
            burst_len = '0;
            burst_len[1*BURST_W +: BURST_W] = BURST_W'(20);
            @(negedge clk);
            check("abort_gnt", 32'(gnt), 32'h2);
            en_cnt   = 0;
            got_done = 1'b0;
            dropped  = 1'b0;
            for (int c = 0; c < 60 && !got_done; c++) begin
                @(negedge clk);
                if (cnt_en) en_cnt++;
                if (done != '0) begin
                    got_done = 1'b1;
                    check("abort_done", 32'(done), 32'h2);
                    check("abort_flag", 32'(aborted), 32'd1);
                end
                if (en_cnt == 5 && !dropped) begin
                    req     = '0;
                    dropped = 1'b1;
                end
            end
            check("abort_done_seen", 32'(got_done), 32'd1);
            check("abort_enables", 32'(en_cnt >= 5 && en_cnt <= 6), 32'd1);
        end

        // Reset asserted mid-RUN drops grant and enable immediately
        @(negedge clk);
        req       = 4'b0001;
        burst_len = '0;
        burst_len[0 +: BURST_W] = BURST_W'(20);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst_run_en", 32'(cnt_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_after", 32'({gnt, cnt_en, busy, done}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
